// File: rtl/fetch_queue.sv
// Fetch queue: circular FIFO of {instr, pc, adel} between I-cache fetch and the decoder.
// Build option FETCH_QUEUE_BYPASS_EN forwards an offered entry straight to out_* while empty.
module fetch_queue #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [31:0]      in_pc,
  input  logic             in_adel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_pcplus4,
  output logic             out_adel,
  output logic [PTR_W:0]   count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             empty, full, push, pop, mem_we, bypass;
  entry_t           head, in_entry;

  // Pointer MSB is the wrap bit: equal indices are empty or full depending on it.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                    (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
  assign in_entry = '{instr: in_instr, pc: in_pc, adel: in_adel};
  assign head     = mem_q[rd_ptr_q[PTR_W-1:0]];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = empty & in_valid & ~flush;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready  = ~full;
  assign out_valid = ~empty | bypass;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = wr_ptr_q - rd_ptr_q;

  // Next pointers; flush wins, and a consumed bypass entry never touches storage.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_we   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else if (!(bypass && pop)) begin
      if (push) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= in_entry;
    end
  end

  // Head fields read zero while nothing is presented.
  always_comb begin
    out_instr = '0;
    out_pc    = '0;
    out_adel  = 1'b0;
    if (bypass) begin
      out_instr = in_instr;
      out_pc    = in_pc;
      out_adel  = in_adel;
    end else if (!empty) begin
      out_instr = head.instr;
      out_pc    = head.pc;
      out_adel  = head.adel;
    end
  end

  assign out_pcplus4 = out_pc + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: driver queues expected entries, a negedge monitor checks them.
module tb_fetch_queue;

  localparam int DEPTH = 8;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        adel;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        in_adel = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pcplus4;
  logic        out_adel;
  logic [3:0]  count;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .in_adel(in_adel),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_adel(out_adel),
    .count(count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   mcount = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   p_acc, p_pop, p_fl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Apply inputs and record what the queue must do with them.
  task automatic drive(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                       input bit ad, input bit ordy, input bit fl);
    exp_t e;
    in_valid = iv; in_instr = ins; in_pc = pc; in_adel = ad;
    out_ready = ordy; flush = fl;
    p_fl  = fl;
    p_acc = iv && !fl && (mcount < DEPTH);
    p_pop = ordy && !fl && ((mcount != 0) || (BYP && iv && mcount == 0));
    if (fl) exp_q.delete();
    else if (p_acc) begin
      e.instr = ins; e.pc = pc; e.adel = ad;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (p_fl) mcount = 0;
    else mcount = mcount + int'(p_acc) - int'(p_pop);
    #1;
  endtask

  task automatic cyc(input bit iv, input logic [31:0] ins, input logic [31:0] pc,
                     input bit ad, input bit ordy, input bit fl);
    drive(iv, ins, pc, ad, ordy, fl);
    tick();
  endtask

  // Monitor: flags and occupancy every cycle, head contents on every pop.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        check("out_valid", 32'(out_valid),
              32'((mcount != 0) || (BYP && in_valid && !flush && mcount == 0)));
        check("count", 32'(count), 32'(mcount));
        check("in_ready", 32'(in_ready), 32'(mcount != DEPTH));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pop_pc", out_pc, 32'hxxxx_xxxx);
          end else begin
            e = exp_q.pop_front();
            check("pop_pc", out_pc, e.pc);
            check("pop_instr", out_instr, e.instr);
            check("pop_adel", 32'(out_adel), 32'(e.adel));
            check("pop_pcplus4", out_pcplus4, e.pc + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_pcplus4", out_pcplus4, 32'd4);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // Same-cycle visibility only with the bypass build
    drive(1, 32'h1234_5678, 32'h8000_0000, 0, 1, 0);
    #2;
    check("lat_out_valid", 32'(out_valid), 32'(BYP));
    check("lat_out_pc", out_pc, BYP ? 32'h8000_0000 : 32'h0);
    tick();
    check("lat_count", 32'(count), BYP ? 32'd0 : 32'd1);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    // Fill, then an extra offer that must be refused
    for (int i = 0; i < 8; i++)
      cyc(1, 32'hA000_0000 + 32'(i), 32'h1000 + 32'(4 * i), i == 3, 0, 0);
    check("fill_count", 32'(count), 32'd8);
    check("fill_in_ready", 32'(in_ready), 32'd0);
    check("fill_head_pc", out_pc, 32'h1000);
    check("fill_pcplus4", out_pcplus4, 32'h1004);
    cyc(1, 32'hDEAD_0000, 32'hDEAD_0000, 0, 0, 0);
    check("full_hold_pc", out_pc, 32'h1000);

    // Drain in order
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 1, 0);
    check("drain_count", 32'(count), 32'd0);
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Full with pop and offer: only the pop happens
    for (int i = 0; i < 8; i++)
      cyc(1, 32'hB000_0000 + 32'(i), 32'h2000 + 32'(4 * i), 0, 0, 0);
    cyc(1, 32'hDEAD_0001, 32'hDEAD_0004, 0, 1, 0);
    check("fulledge_count", 32'(count), 32'd7);
    check("fulledge_head_pc", out_pc, 32'h2004);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 0);

    // Stream from half full across pointer wraps
    for (int i = 0; i < 4; i++)
      cyc(1, 32'hC000_0000 + 32'(i), 32'h3000 + 32'(4 * i), 0, 0, 0);
    for (int i = 4; i < 24; i++)
      cyc(1, 32'hC000_0000 + 32'(i), 32'h3000 + 32'(4 * i), i[0], 1, 0);
    check("stream_count", 32'(count), 32'd4);
    check("stream_head_pc", out_pc, 32'h3050);

    // Flush at count 5 with a simultaneous offer
    cyc(1, 32'hC000_0018, 32'h3060, 0, 0, 0);
    check("preflush_count", 32'(count), 32'd5);
    cyc(1, 32'hBAD0_0000, 32'hBAD0_0000, 0, 0, 1);
    check("flush_count", 32'(count), 32'd0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    check("flush_empty_count", 32'(count), 32'd0);

    // PC+4 wraps to zero
    cyc(1, 32'h0000_0013, 32'hFFFF_FFFC, 1, 0, 0);
    check("wrap_pcplus4", out_pcplus4, 32'h0);
    check("wrap_adel", 32'(out_adel), 32'd1);
    cyc(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++)
      cyc(1, 32'hE000_0000 + 32'(i), 32'h4000 + 32'(4 * i), 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    exp_q.delete();
    mcount = 0;
    p_acc = 0; p_pop = 0; p_fl = 0;
    #1;
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_pc", out_pc, 32'h0);
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc(1, 32'hF000_0000, 32'h5000, 0, 0, 0);
    check("postrst_head_pc", out_pc, 32'h5000);
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
